// File: rtl/controller_pkg.sv
// controller_pkg: constants and types shared by the controller's response path.
//   ASCII_CR / ASCII_LF : line terminators used in response words
//   UART_FRAME_BITS     : start + 8 data + stop
//   RESP_MAX_BYTES      : bytes carried by one response word
//   tx_state_t          : serialiser state encoding
package controller_pkg;
    localparam logic [7:0] ASCII_CR        = 8'h0D;
    localparam logic [7:0] ASCII_LF        = 8'h0A;
    localparam int         UART_FRAME_BITS = 10;
    localparam int         RESP_MAX_BYTES  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serialiser for one character.
//   clk   in  : system clock
//   rst   in  : asynchronous active-low reset
//   start in  : load data and begin a start bit on this edge (accepted in IDLE
//               or on the final cycle of a stop bit, so bytes chain gaplessly)
//   data  in  : character, bit 0 sent first
//   tx    out : serial line, idle high (registered)
//   done  out : high during the last cycle of the stop bit (registered)
module uart_tx_byte
    import controller_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  tx,
    output logic                  done
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_LOAD   = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_WIDTH - 1);

    tx_state_t             r_state;
    logic [TW-1:0]         r_timer;
    logic [2:0]            r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_tx;
    logic                  r_done;

    assign tx   = r_tx;
    assign done = r_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else if (start && (r_state == IDLE || r_done)) begin
            // start bit is on the line from the accepting edge onward
            r_state   <= START;
            r_timer   <= T_LOAD;
            r_bit_idx <= '0;
            r_shift   <= data;
            r_tx      <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // done is raised one cycle ahead so it covers the final stop cycle
            r_done <= (r_state == STOP) && (r_timer == TW'(1));
            case (r_state)
                IDLE: r_tx <= 1'b1;
                START: begin
                    if (r_timer == '0) begin
                        r_state <= DATA;
                        r_timer <= T_LOAD;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                DATA: begin
                    if (r_timer == '0) begin
                        r_timer <= T_LOAD;
                        if (r_bit_idx == LAST_BIT) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                STOP: begin
                    if (r_timer == '0) begin
                        r_state <= IDLE;
                        r_tx    <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: rtl/response_sender.sv
// response_sender: sends up to four bytes of a response word over UART, LSB first.
//   clk                in  : system clock
//   rst                in  : asynchronous active-low reset
//   send_data_register in  : response word, byte 0 = [7:0] sent first
//   size_line          in  : byte count, clamped to 4; 0 means nothing to send
//   valid_data         in  : word/size valid; captured only while not busy
//   busy_sender_data   out : high from capture until the last stop bit ends
//   tx                 out : serial line, idle high
module response_sender
    import controller_pkg::*;
#(
    parameter int WORD_SIZE    = 32,
    parameter int SIZE_WORD    = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] send_data_register,
    input  logic [SIZE_WORD-1:0] size_line,
    input  logic                 valid_data,
    output logic                 busy_sender_data,
    output logic                 tx
);
    logic [WORD_SIZE-1:0]  r_word;
    logic [2:0]            r_count;
    logic [1:0]            r_byte_idx;
    logic                  r_busy;

    logic [2:0]            w_count;
    logic                  w_capture;
    logic                  w_more;
    logic                  w_done;
    logic                  w_start;
    logic [DATA_WIDTH-1:0] w_byte;

    assign w_count   = (size_line > SIZE_WORD'(RESP_MAX_BYTES)) ? 3'(RESP_MAX_BYTES)
                                                                : 3'(size_line);
    assign w_capture = valid_data && !r_busy && (w_count != 3'd0);
    assign w_more    = ({1'b0, r_byte_idx} + 3'd1) < r_count;
    // the next byte is launched on the same edge the previous stop bit ends
    assign w_start   = w_capture || (w_done && w_more);
    // first byte bypasses the latch so its start bit begins on the capture edge
    assign w_byte    = w_capture ? send_data_register[DATA_WIDTH-1:0]
                                 : r_word[DATA_WIDTH-1:0];

    assign busy_sender_data = r_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word     <= '0;
            r_count    <= '0;
            r_byte_idx <= '0;
            r_busy     <= 1'b0;
        end else if (w_capture) begin
            r_word     <= send_data_register >> DATA_WIDTH;
            r_count    <= w_count;
            r_byte_idx <= '0;
            r_busy     <= 1'b1;
        end else if (w_done) begin
            r_byte_idx <= r_byte_idx + 1'b1;
            if (w_more) r_word <= r_word >> DATA_WIDTH;
            else        r_busy <= 1'b0;
        end
    end

    uart_tx_byte #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .start(w_start),
        .data (w_byte),
        .tx   (tx),
        .done (w_done)
    );
endmodule

// File: tb/tb_response_sender.sv
module tb_response_sender;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] word = '0;
    logic [2:0]  size = '0;
    logic        valid = 1'b0;
    logic        busy;
    logic        tx;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    response_sender #(
        .WORD_SIZE(32), .SIZE_WORD(3), .DATA_WIDTH(8), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk), .rst(rst), .send_data_register(word), .size_line(size),
        .valid_data(valid), .busy_sender_data(busy), .tx(tx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: decodes 8N1 frames sampled on negedges and pops the scoreboard.
    initial begin
        logic [7:0] b;
        logic       abort;
        forever begin
            @(negedge clk);
            if (rst && tx === 1'b0) begin
                abort = 1'b0;
                b = '0;
                for (int k = 1; k <= 38; k++) begin
                    @(negedge clk);
                    if (!rst) begin abort = 1'b1; break; end
                    if (k == 2) chk("start_bit", {31'd0, tx}, 32'd0);
                    if (k >= 6 && k <= 34 && ((k - 6) % 4) == 0) b[(k - 6) / 4] = tx;
                    if (k == 38) chk("stop_bit", {31'd0, tx}, 32'd1);
                end
                if (!abort) begin
                    if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, b}, 32'hFFFF_FFFF);
                    else chk("rx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Present a word for one cycle; returns on the negedge after the sampling edge.
    task automatic issue(input logic [31:0] w, input logic [2:0] s, input bit expect_cap);
        @(negedge clk);
        word = w; size = s; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        if (expect_cap) begin
            chk("busy_on_capture", {31'd0, busy}, 32'd1);
            chk("tx_on_capture",   {31'd0, tx},   32'd0);
        end
    endtask

    // Counts negedges with busy high, starting at the current one.
    task automatic measure_busy(input string name, input int exp);
        int cnt = 0;
        while (busy === 1'b1 && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        chk(name, cnt, exp);
    endtask

    task automatic push_word(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(w[8*i +: 8]);
    endtask

    initial begin
        int  t;
        bit  ok;
        // 1. reset
        repeat (3) @(negedge clk);
        chk("reset_tx",   {31'd0, tx},   32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        chk("post_reset_idle", {31'd0, ok}, 32'd1);

        // 2. full word
        push_word(32'h0D0A4B4F, 4);
        issue(32'h0D0A4B4F, 3'd4, 1'b1);
        measure_busy("busy_len_full", 160);
        chk("tx_idle_after_full", {31'd0, tx}, 32'd1);
        chk("queue_drained_full", exp_q.size(), 0);

        // 3. short word
        push_word(32'h0D0A3146, 2);
        issue(32'h0D0A3146, 3'd2, 1'b1);
        measure_busy("busy_len_short", 80);
        chk("queue_drained_short", exp_q.size(), 0);

        // 4a. size 0 -> no capture
        issue(32'h0D0A4B4F, 3'd0, 1'b0);
        ok = 1'b1;
        repeat (20) begin
            if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        chk("size0_no_capture", {31'd0, ok}, 32'd1);

        // 4b. size 7 clamps to 4
        push_word(32'h0D595342, 4);
        issue(32'h0D595342, 3'd7, 1'b1);
        measure_busy("busy_len_clamp", 160);
        chk("queue_drained_clamp", exp_q.size(), 0);

        // 5a. valid pulse while busy is ignored
        push_word(32'h0D0A4B4F, 4);
        issue(32'h0D0A4B4F, 3'd4, 1'b1);
        fork
            measure_busy("busy_len_ignore", 160);
            begin
                repeat (50) @(negedge clk);
                word = 32'h0D0A2030; size = 3'd4; valid = 1'b1;
                @(negedge clk);
                valid = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        chk("queue_drained_ignore", exp_q.size(), 0);

        // 5b. valid held across busy fall -> recaptured one cycle later
        push_word(32'h0D0A3146, 2);
        push_word(32'h0D0A3146, 2);
        @(negedge clk);
        word = 32'h0D0A3146; size = 3'd2; valid = 1'b1;
        @(negedge clk);
        chk("held_first_capture", {31'd0, busy}, 32'd1);
        t = 0;
        while (busy === 1'b1 && t < 200) begin t++; @(negedge clk); end
        chk("held_first_len", t, 80);
        chk("held_gap_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        valid = 1'b0;
        chk("held_recapture_busy", {31'd0, busy}, 32'd1);
        chk("held_recapture_tx",   {31'd0, tx},   32'd0);
        measure_busy("busy_len_recapture", 80);
        chk("queue_drained_held", exp_q.size(), 0);

        // 6. reset during bit 3 of byte 1
        exp_q.push_back(8'h4F);
        issue(32'h0D0A4B4F, 3'd4, 1'b1);
        repeat (57) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_tx",   {31'd0, tx},   32'd1);
        chk("async_reset_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        chk("queue_after_abort", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        chk("idle_after_reset", {31'd0, tx}, 32'd1);
        push_word(32'h0D0A4B4F, 4);
        issue(32'h0D0A4B4F, 3'd4, 1'b1);
        measure_busy("busy_len_after_reset", 160);
        repeat (50) @(negedge clk);
        chk("queue_drained_final", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
